// File: rtl/graphic_register_scheduler_if.sv
// CPU-side and register-side signals of the sprite register update scheduler.
// master: CPU / VGA timing side driving pushes and vblank. slave: the scheduler.
interface graphic_register_scheduler_if #(
  parameter int unsigned N_SPRITES  = 8,
  parameter int unsigned FIFO_DEPTH = 4
);
  localparam int unsigned AW = $clog2(N_SPRITES);
  localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1;

  logic                 cpu_write;
  logic [AW-1:0]        cpu_addr;
  logic [31:0]          cpu_data;
  logic                 cpu_ready;
  logic                 vblank;
  logic [N_SPRITES-1:0] reg_write;
  logic [31:0]          reg_write_data;
  logic [PW-1:0]        pending;
  logic                 busy;
  logic                 overflow;
  logic                 late;

  modport master (
    output cpu_write, cpu_addr, cpu_data, vblank,
    input  cpu_ready, reg_write, reg_write_data, pending, busy, overflow, late
  );

  modport slave (
    input  cpu_write, cpu_addr, cpu_data, vblank,
    output cpu_ready, reg_write, reg_write_data, pending, busy, overflow, late
  );
endinterface

// File: rtl/graphic_register_scheduler.sv
// Frame-atomic sprite register update scheduler. CPU writes are queued in a
// small FIFO; on each vblank rising edge the entries queued at that edge are
// replayed one per cycle as one-hot register write strobes.
module graphic_register_scheduler #(
  parameter int unsigned N_SPRITES  = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input logic                          clk,
  input logic                          rst,
  graphic_register_scheduler_if.slave  bus
);
  localparam int unsigned AW   = $clog2(N_SPRITES);
  localparam int unsigned PtrW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW   = PtrW + 1;

  typedef enum logic [0:0] {StIdle, StCommit} state_e;

  state_e               state_q;
  logic [AW-1:0]        addr_mem [FIFO_DEPTH];
  logic [31:0]          data_mem [FIFO_DEPTH];
  logic [PtrW-1:0]      wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, batch_q;
  logic                 vblank_q;
  logic                 overflow_q, late_q;
  logic [N_SPRITES-1:0] reg_write_q;
  logic [31:0]          reg_write_data_q;

  logic full, pop, push, rise, fall;

  assign full = (count_q == CW'(FIFO_DEPTH));
  // Every COMMIT cycle pops; the batch never exceeds the FIFO occupancy.
  assign pop  = (state_q == StCommit);
  // A pop frees a slot in the same cycle, so a push while full still fits.
  assign push = bus.cpu_write && (!full || pop);
  assign rise = bus.vblank && !vblank_q;
  assign fall = !bus.vblank && vblank_q;

  assign bus.cpu_ready      = !full;
  assign bus.pending        = count_q;
  assign bus.busy           = pop;
  assign bus.overflow       = overflow_q;
  assign bus.late           = late_q;
  assign bus.reg_write      = reg_write_q;
  assign bus.reg_write_data = reg_write_data_q;

  // FIFO storage; contents need no reset since occupancy is tracked by count_q.
  always_ff @(posedge clk) begin
    if (push) begin
      addr_mem[wr_ptr_q] <= bus.cpu_addr;
      data_mem[wr_ptr_q] <= bus.cpu_data;
    end
  end

  // FIFO pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
      if (bus.cpu_write && !push) overflow_q <= 1'b1;
    end
  end

  // Commit FSM: latch batch size on vblank rise, then strobe one entry per cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= StIdle;
      batch_q          <= '0;
      vblank_q         <= 1'b0;
      late_q           <= 1'b0;
      reg_write_q      <= '0;
      reg_write_data_q <= '0;
    end else begin
      vblank_q    <= bus.vblank;
      reg_write_q <= '0;
      unique case (state_q)
        StIdle: begin
          if (rise && (count_q != '0)) begin
            state_q <= StCommit;
            batch_q <= count_q;
          end
        end
        StCommit: begin
          // A second rise here is a glitch and deliberately does not reload.
          reg_write_q      <= N_SPRITES'(1) << addr_mem[rd_ptr_q];
          reg_write_data_q <= data_mem[rd_ptr_q];
          batch_q          <= batch_q - CW'(1);
          if (batch_q == CW'(1)) state_q <= StIdle;
          if (fall) late_q <= 1'b1;
        end
        default: state_q <= StIdle;
      endcase
    end
  end
endmodule

// File: tb/tb_graphic_register_scheduler.sv
// Scoreboard bench: a queue-level model predicts committed strobes, a monitor
// compares every DUT output on the falling clock edge.
module tb_graphic_register_scheduler;
  localparam int unsigned N  = 8;
  localparam int unsigned D  = 4;
  localparam int unsigned AW = $clog2(N);

  typedef struct packed {
    logic [AW-1:0] a;
    logic [31:0]   d;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  graphic_register_scheduler_if #(.N_SPRITES(N), .FIFO_DEPTH(D)) bus ();

  graphic_register_scheduler #(.N_SPRITES(N), .FIFO_DEPTH(D)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int   checks  = 0;
  int   errors  = 0;
  int   strobes = 0;
  bit   mon_en  = 0;

  // Reference model state.
  ent_t m_q[$];
  ent_t exp_q[$];
  int   batch_left = 0;
  bit   prev_vb = 0;
  bit   m_ovf = 0;
  bit   m_late = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Model: FIFO as a queue; a vblank rise while idle freezes the current
  // occupancy as the batch; each batch cycle moves the head to the expected list.
  initial begin : model
    int sz;
    bit pop;
    forever begin
      @(posedge clk);
      if (rst) begin
        m_q.delete();
        exp_q.delete();
        batch_left = 0;
        prev_vb    = 0;
        m_ovf      = 0;
        m_late     = 0;
      end else begin
        sz  = m_q.size();
        pop = (batch_left > 0);
        if (pop) begin
          exp_q.push_back(m_q.pop_front());
          batch_left--;
        end
        if (bus.cpu_write) begin
          if (sz < D || pop) m_q.push_back('{a: bus.cpu_addr, d: bus.cpu_data});
          else m_ovf = 1;
        end
        if (!pop && bus.vblank && !prev_vb && sz > 0) batch_left = sz;
        if (pop && !bus.vblank && prev_vb) m_late = 1;
        prev_vb = bus.vblank;
      end
    end
  end

  // Monitor: compare status every cycle, pop the scoreboard on each strobe.
  initial begin : monitor
    ent_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        chk("pending", 64'(bus.pending), 64'(m_q.size()));
        chk("cpu_ready", 64'(bus.cpu_ready), 64'(m_q.size() < D));
        chk("busy", 64'(bus.busy), 64'(batch_left > 0));
        chk("overflow", 64'(bus.overflow), 64'(m_ovf));
        chk("late", 64'(bus.late), 64'(m_late));
        if (bus.reg_write != '0) begin
          strobes++;
          if (exp_q.size() == 0) begin
            chk("unexpected_strobe", 64'(bus.reg_write), 64'(0));
          end else begin
            e = exp_q.pop_front();
            chk("strobe_mask", 64'(bus.reg_write), 64'(1) << e.a);
            chk("strobe_data", 64'(bus.reg_write_data), 64'(e.d));
          end
        end else if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("missing_strobe", 64'(bus.reg_write), 64'(1) << e.a);
        end
      end
    end
  end

  // One cycle of stimulus, applied at the falling edge.
  task automatic cyc(input bit wr, input int addr, input logic [31:0] data, input bit vb);
    bus.cpu_write = wr;
    bus.cpu_addr  = AW'(addr);
    bus.cpu_data  = data;
    bus.vblank    = vb;
    @(negedge clk);
  endtask

  task automatic idle(input int n, input bit vb);
    for (int i = 0; i < n; i++) cyc(0, 0, 32'h0, vb);
  endtask

  task automatic do_reset();
    rst = 1;
    idle(2, 0);
    rst = 0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin : stim
    int s0;
    int vb_len;
    bit vb;
    bus.cpu_write = 0;
    bus.cpu_addr  = '0;
    bus.cpu_data  = '0;
    bus.vblank    = 0;
    @(negedge clk);
    do_reset();
    mon_en = 1;

    // Basic three-entry frame with a duplicate address.
    s0 = strobes;
    cyc(1, 2, 32'h0040_0000, 0);
    cyc(1, 5, 32'h1234_5678, 0);
    cyc(1, 2, 32'h0080_0000, 0);
    chk("t1_pending_before", 64'(bus.pending), 64'd3);
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t1_first_strobe", 64'(bus.reg_write), 64'h04);
    chk("t1_busy", 64'(bus.busy), 64'd1);
    idle(8, 1);
    idle(3, 0);
    chk("t1_strobe_count", 64'(strobes - s0), 64'd3);
    chk("t1_pending_after", 64'(bus.pending), 64'd0);

    // Fill past full: the fifth push is dropped.
    for (int i = 0; i < 5; i++) begin
      cyc(1, i, 32'hA000_0000 + 32'(i), 0);
      if (i == 3) chk("t2_ready_full", 64'(bus.cpu_ready), 64'd0);
    end
    chk("t2_overflow", 64'(bus.overflow), 64'd1);
    chk("t2_pending_full", 64'(bus.pending), 64'd4);
    s0 = strobes;
    idle(7, 1);
    idle(3, 0);
    chk("t2_strobe_count", 64'(strobes - s0), 64'd4);

    // Push during commit lands behind the batch.
    cyc(1, 1, 32'hB000_0001, 0);
    cyc(1, 3, 32'hB000_0003, 0);
    s0 = strobes;
    cyc(0, 0, 0, 1);
    cyc(1, 7, 32'hB000_0007, 1);
    idle(5, 1);
    idle(3, 0);
    chk("t3_strobe_count", 64'(strobes - s0), 64'd2);
    chk("t3_pending_left", 64'(bus.pending), 64'd1);
    s0 = strobes;
    cyc(0, 0, 0, 1);
    cyc(0, 0, 0, 1);
    chk("t3_addr7_strobe", 64'(bus.reg_write), 64'h80);
    idle(3, 1);
    idle(3, 0);
    chk("t3_second_frame", 64'(strobes - s0), 64'd1);

    // Push into a full FIFO on a pop cycle is accepted.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, i + 2, 32'hC000_0000 + 32'(i), 0);
    s0 = strobes;
    cyc(0, 0, 0, 1);
    cyc(1, 6, 32'hC000_0006, 1);
    chk("t4_no_overflow", 64'(bus.overflow), 64'd0);
    chk("t4_pending_same", 64'(bus.pending), 64'd4);
    idle(6, 1);
    idle(3, 0);
    chk("t4_strobe_count", 64'(strobes - s0), 64'd4);
    chk("t4_pending_left", 64'(bus.pending), 64'd1);

    // Short vblank plus a glitch pulse during commit.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, 7 - i, 32'hD000_0000 + 32'(i), 0);
    s0 = strobes;
    idle(2, 1);
    idle(1, 0);
    idle(1, 1);
    idle(6, 0);
    chk("t5_strobe_count", 64'(strobes - s0), 64'd4);
    chk("t5_late", 64'(bus.late), 64'd1);
    chk("t5_pending", 64'(bus.pending), 64'd0);

    // Reset mid-batch abandons the remaining strobes.
    do_reset();
    for (int i = 0; i < 4; i++) cyc(1, i, 32'hE000_0000 + 32'(i), 0);
    s0 = strobes;
    idle(3, 1);
    rst = 1;
    idle(1, 1);
    rst = 0;
    idle(4, 1);
    idle(2, 0);
    chk("t6_strobes_before_reset", 64'(strobes - s0), 64'd2);
    chk("t6_pending", 64'(bus.pending), 64'd0);
    chk("t6_busy", 64'(bus.busy), 64'd0);
    s0 = strobes;
    idle(4, 1);
    idle(2, 0);
    chk("t6_empty_vblank", 64'(strobes - s0), 64'd0);

    // Randomized traffic with irregular vblank lengths.
    vb = 0;
    vb_len = 5;
    for (int c = 0; c < 600; c++) begin
      if (vb_len == 0) begin
        vb = ~vb;
        vb_len = int'($urandom_range(1, 12));
      end
      vb_len--;
      cyc(bit'($urandom_range(0, 1)), int'($urandom_range(0, N - 1)), $urandom, vb);
    end

    // Drain whatever is left with one clean frame.
    idle(3, 0);
    idle(12, 1);
    idle(3, 0);
    chk("final_scoreboard_empty", 64'(exp_q.size()), 64'd0);
    chk("final_pending", 64'(bus.pending), 64'(m_q.size()));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/graphic_register_scheduler.md
Name: graphic_register_scheduler

Overview:
- Frame-atomic update scheduler for the bank of sprite graphic registers in the GPU.
- The CPU posts 32-bit sprite words into a small FIFO at any time: Y [31:22], X [21:12], colour/invisible [11:6], base [5:0].
- On each vertical-blank rising edge, the block commits the entries that were queued at that edge, one register write per cycle, as one-hot WRITE strobes. Sprites therefore never tear mid-frame.

Parameters:
- N_SPRITES, 8, number of graphic registers driven; power of two, 2..32.
- FIFO_DEPTH, 4, pending-write queue depth; power of two, 2..16.
- AW, $clog2(N_SPRITES), sprite index width; derived, do not override.

Ports:
- CLK  input  1  system clock.
- RST  input  1  synchronous, active-high reset.
- CPU_WRITE  input  1  push request; one entry per cycle while high.
- CPU_ADDR  input  AW  target sprite index.
- CPU_DATA  input  32  sprite word.
- CPU_READY  output  1  high when FIFO not full; combinational from count.
- VBLANK  input  1  vertical-blank level from the VGA timing block; synchronous to CLK.
- REG_WRITE  output  N_SPRITES  one-hot write strobes to the graphic registers; registered.
- REG_WRITE_DATA  output  32  word for the strobed register; registered.
- PENDING  output  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- BUSY  output  1  high while in COMMIT.
- OVERFLOW  output  1  sticky: a push was dropped because the FIFO was full.
- LATE  output  1  sticky: VBLANK fell while COMMIT still had entries left.

Behaviour:
- Reset (RST=1 at a clock edge):
  - FIFO flushed, PENDING=0, state IDLE.
  - REG_WRITE=0, REG_WRITE_DATA=0, BUSY=0, OVERFLOW=0, LATE=0, VBLANK_Q=0.
  - Reset mid-COMMIT abandons the batch; no further strobes.
- Edge detect:
  - VBLANK_Q registers VBLANK.
  - RISE = VBLANK & ~VBLANK_Q.
- States: IDLE and COMMIT.
  - IDLE -> COMMIT when RISE and PENDING>0; BATCH <= PENDING at that edge.
  - RISE with PENDING=0 stays IDLE.
  - COMMIT: each cycle pops the head entry, drives REG_WRITE[addr]=1 and REG_WRITE_DATA=word on the next cycle, and decrements BATCH.
  - COMMIT -> IDLE on the pop that makes BATCH=0.
- Latency: VBLANK first sampled high at edge k gives strobes in the cycles after edges k+1 .. k+BATCH, i.e. BATCH consecutive single-cycle pulses.
- Ordering:
  - Strict FIFO.
  - Duplicate addresses are not coalesced; the last write wins in the register.
- Pushes during COMMIT are accepted if not full. They land behind the batch and are not committed until the next RISE.
- Simultaneous push and pop in one cycle: both take effect; PENDING unchanged.
- Full:
  - CPU_READY=0.
  - A push while full is dropped and OVERFLOW sets.
  - A push while full in the same cycle as a pop is accepted; no overflow.
- VBLANK falls before BATCH=0: commit continues to completion and LATE sets. It is a diagnostic only.
- RISE while in COMMIT (VBLANK glitch): ignored; BATCH not reloaded.
- REG_WRITE is 0 on every cycle without a pop. At most one bit is set per cycle.
- Pointers wrap modulo FIFO_DEPTH. PENDING spans 0..FIFO_DEPTH inclusive.

Test Plan:
- Reset then 3 pushes (addr 2,5,2; data 0x00400000, 0x12345678, 0x00800000), then raise VBLANK at edge k:
  - PENDING 3 -> 0.
  - REG_WRITE = 0x04, 0x20, 0x04 after edges k+1..k+3, with matching data.
  - BUSY high across those three cycles, then 0.
- FIFO_DEPTH=4: push 5 words with VBLANK low:
  - CPU_READY=0 after the 4th push.
  - 5th push dropped, OVERFLOW=1, PENDING=4.
  - Next vblank emits exactly 4 strobes.
- During COMMIT of 2 entries, push addr 7:
  - Only 2 strobes this frame; PENDING=1 afterwards.
  - The addr-7 strobe (REG_WRITE=0x80) appears only after the next RISE.
- Full FIFO in COMMIT, push on a pop cycle:
  - Push accepted, OVERFLOW stays 0, PENDING unchanged on that cycle.
- VBLANK high for 2 cycles with 4 pending:
  - All 4 strobes still emitted, LATE=1.
  - A second VBLANK pulse during COMMIT causes no reload.
- Assert RST after the 2nd strobe of a 4-entry batch:
  - No further strobes, PENDING=0, BUSY=0, flags cleared.
  - A following vblank with an empty FIFO produces no strobes.
